// File: rtl/lr2_ctrl_pkg.sv
// lr2_ctrl_pkg: shared state encoding and default widths for the LR2 step scheduler
package lr2_ctrl_pkg;
    localparam int LR2_PERIOD_W = 4;
    localparam int LR2_BURST_W  = 4;
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10} sched_state_t;
endpackage

// File: rtl/lr2_sync2.sv
// lr2_sync2: two-flop synchroniser; INIT is the value forced asynchronously while arst_n is low
module lr2_sync2 #(
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) {q, meta} <= {2{INIT}};
        else         {q, meta} <= {meta, d};
endmodule

// File: rtl/lr2_step_scheduler.sv
// lr2_step_scheduler: merges manual step/load requests with period-timed auto stepping for the LR2 core
module lr2_step_scheduler
    import lr2_ctrl_pkg::*;
#(
    parameter int PERIOD_W = LR2_PERIOD_W,
    parameter int BURST_W  = LR2_BURST_W
) (
    input  logic                clk,
    input  logic                btnCpuReset,
    input  logic                tick_ce,
    input  logic                step_req,
    input  logic                load_req,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst_len,
    output logic                seq_ce,
    output logic                seq_load,
    output logic                busy,
    output logic [1:0]          mode
);
    sched_state_t        state, state_d;
    logic [PERIOD_W-1:0] per_q, per_d, tcnt, tcnt_d, tcnt_inc;
    logic [BURST_W-1:0]  bcnt, bcnt_d;
    logic                rst_i, rst_n, auto_s, auto_q, auto_rise;
    logic                pending, pend_d, ce_d, load_d, run, auto_hit, want, auto_step;

    lr2_sync2 #(.INIT(1'b1)) u_rst_sync (.clk(clk), .arst_n(btnCpuReset), .d(1'b0), .q(rst_i));
    assign rst_n = ~rst_i;
    lr2_sync2 #(.INIT(1'b0)) u_auto_sync (.clk(clk), .arst_n(rst_n), .d(auto_en), .q(auto_s));

    assign auto_rise = auto_s & ~auto_q;
    assign mode      = state;
    assign busy      = state == RUN;

    // In RUN, bcnt==0 can only mean continuous mode, since a burst leaves RUN when it reaches 0
    always_comb begin
        state_d   = state;
        per_d     = per_q;
        bcnt_d    = bcnt;
        tcnt_d    = tcnt;
        tcnt_inc  = tcnt + PERIOD_W'(1);
        run       = (state == RUN) && auto_s;
        auto_hit  = run && tick_ce && (tcnt_inc == per_q);
        want      = run && (auto_hit || pending);
        auto_step = want && !load_req;
        ce_d      = !load_req && (want || step_req);
        load_d    = load_req;
        pend_d    = want && load_req;
        if (run && tick_ce) tcnt_d = auto_hit ? '0 : tcnt_inc;
        if (run && load_req) tcnt_d = '0;
        if (auto_step && bcnt != '0) bcnt_d = bcnt - BURST_W'(1);
        if (auto_step && bcnt == BURST_W'(1)) state_d = HOLD;
        if (state == IDLE && auto_rise) begin
            state_d = RUN;
            per_d   = (period == '0) ? PERIOD_W'(1) : period;
            bcnt_d  = burst_len;
            tcnt_d  = '0;
            pend_d  = 1'b0;
        end
        if (state != IDLE && !auto_s) begin
            state_d = IDLE;
            tcnt_d  = '0;
            bcnt_d  = '0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_i)
        if (rst_i) begin
            state    <= IDLE;
            per_q    <= '0;
            tcnt     <= '0;
            bcnt     <= '0;
            pending  <= 1'b0;
            auto_q   <= 1'b0;
            seq_ce   <= 1'b0;
            seq_load <= 1'b0;
        end else begin
            state    <= state_d;
            per_q    <= per_d;
            tcnt     <= tcnt_d;
            bcnt     <= bcnt_d;
            pending  <= pend_d;
            auto_q   <= auto_s;
            seq_ce   <= ce_d;
            seq_load <= load_d;
        end
endmodule

// File: tb/tb_lr2_step_scheduler.sv
// tb_lr2_step_scheduler: table-driven directed vectors plus reset sequences for lr2_step_scheduler
module tb_lr2_step_scheduler;
    logic       clk = 0, btnCpuReset = 0, tick_ce = 0, step_req = 0, load_req = 0, auto_en = 0;
    logic [3:0] period = 0, burst_len = 0, cur_per = 0, cur_bl = 0;
    logic       seq_ce, seq_load, busy;
    logic [1:0] mode;
    int         checks = 0, errors = 0;

    typedef struct {
        logic       t, s, l, a;
        logic [3:0] per, bl;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    lr2_step_scheduler dut (
        .clk(clk), .btnCpuReset(btnCpuReset), .tick_ce(tick_ce), .step_req(step_req),
        .load_req(load_req), .auto_en(auto_en), .period(period), .burst_len(burst_len),
        .seq_ce(seq_ce), .seq_load(seq_load), .busy(busy), .mode(mode)
    );

    function automatic logic [4:0] outs();
        return {seq_ce, seq_load, busy, mode};
    endfunction

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: ce,ld,busy,mode got %b required %b", name, got, exp);
        end
    endtask

    task automatic add(input logic t, s, l, a, ce, ld, bz, input logic [1:0] md);
        vecs.push_back('{t, s, l, a, cur_per, cur_bl, {ce, ld, bz, md}});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held low with a step request pending: nothing may come out
        step_req = 1;
        repeat (3) tick();
        chk("reset_low", outs(), 5'b0);
        btnCpuReset = 1;
        tick();
        chk("release_edge1", outs(), 5'b0);
        tick();
        chk("release_edge2", outs(), 5'b0);
        tick();
        chk("first_step_after_release", outs(), 5'b10000);
        step_req = 0;
        tick();
        chk("idle_after_step", outs(), 5'b0);

        cur_per = 3; cur_bl = 5;
        add(0,1,0,0, 1,0,0,2'd0);
        add(0,0,0,0, 0,0,0,2'd0);
        add(0,0,1,0, 0,1,0,2'd0);
        add(0,1,1,0, 0,1,0,2'd0);
        add(0,0,0,0, 0,0,0,2'd0);
        add(0,0,0,1, 0,0,0,2'd0);
        add(0,0,0,1, 0,0,0,2'd0);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(0,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(1,1,0,1, 1,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,1,0,1, 1,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,1,1, 0,1,1,2'd1);
        add(0,0,0,1, 1,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,0,2'd2);
        add(1,0,0,1, 0,0,0,2'd2);
        add(1,0,0,1, 0,0,0,2'd2);
        add(1,0,0,1, 0,0,0,2'd2);
        add(0,1,0,1, 1,0,0,2'd2);
        add(0,0,1,1, 0,1,0,2'd2);
        add(1,0,0,0, 0,0,0,2'd2);
        add(0,0,0,0, 0,0,0,2'd2);
        add(0,0,0,0, 0,0,0,2'd0);
        cur_per = 0; cur_bl = 0;
        add(0,0,0,1, 0,0,0,2'd0);
        add(0,0,0,1, 0,0,0,2'd0);
        add(0,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(0,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(1,0,1,1, 0,1,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(0,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(1,0,1,0, 0,1,1,2'd1);
        add(0,0,1,0, 0,1,1,2'd1);
        add(0,0,0,0, 0,0,0,2'd0);
        add(0,0,0,0, 0,0,0,2'd0);
        cur_per = 3;
        add(0,0,0,1, 0,0,0,2'd0);
        add(0,0,0,1, 0,0,0,2'd0);
        add(0,0,0,1, 0,0,1,2'd1);
        cur_per = 1;
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(0,0,1,1, 0,1,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,1,1, 0,1,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 0,0,1,2'd1);
        add(1,0,0,1, 1,0,1,2'd1);
        add(0,0,0,0, 0,0,1,2'd1);
        add(0,0,0,0, 0,0,1,2'd1);
        add(0,0,0,0, 0,0,0,2'd0);

        foreach (vecs[i]) begin
            tick_ce = vecs[i].t; step_req = vecs[i].s; load_req = vecs[i].l;
            auto_en = vecs[i].a; period = vecs[i].per; burst_len = vecs[i].bl;
            tick();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        tick_ce = 0; step_req = 0; load_req = 0; auto_en = 0;

        // an output in flight is cleared as soon as reset asserts
        step_req = 1;
        tick();
        step_req = 0;
        chk("pulse_before_reset", outs(), 5'b10000);
        #2 btnCpuReset = 0;
        #1 chk("async_reset_clears", outs(), 5'b0);
        #20 btnCpuReset = 1;
        repeat (3) tick();
        chk("idle_after_rereset", outs(), 5'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
